// File: rtl/svpwm_pkg.sv
// Shared SVPWM constants: Q16 inverse-Clarke gains and rounding helper.
// Used by both the modulator and the receive-side decoder.
package svpwm_pkg;

  localparam int FRAC_BITS   = 16;
  localparam int K_INV3      = 21845;  // 1/3 in Q16
  localparam int K_INV_SQRT3 = 37837;  // 1/sqrt(3) in Q16
  localparam int ROUND_HALF  = 1 << (FRAC_BITS - 1);

  // Round-half-up and drop the Q16 fraction (arithmetic shift keeps sign).
  function automatic int q16_round(input int prod);
    return (prod + ROUND_HALF) >>> FRAC_BITS;
  endfunction

endpackage

// File: rtl/svpwm_decoder_phase_duty_counter.sv
// Per-phase on-time counter with sync reload, plus the stage-0 duty latch
// that saturates a full-period count (2**N) down to the N-bit maximum.
module phase_duty_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         phase_on,
  input  logic         sync,
  output logic [N-1:0] duty
);

  logic [N:0] cnt;

  // On-time counter: reload with the sync-cycle sample, else count high cycles.
  // Holds at all-ones on over-long windows so a stuck gate never wraps small.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sync) begin
      cnt <= (N+1)'(phase_on);
    end else if (phase_on && (cnt != '1)) begin
      cnt <= cnt + (N+1)'(1);
    end
  end

  // Stage 0: capture the finished window's count, saturated to N bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
    end else if (sync) begin
      duty <= cnt[N] ? '1 : cnt[N-1:0];
    end
  end

endmodule

// File: rtl/svpwm_decoder.sv
// SVPWM receive-side decoder: measures per-phase on-time over each carrier
// window and inverse-Clarke transforms the duties back to alpha/beta.
// Optional feature macro: SVPWM_DEC_TIMEOUT_EN (missing-sync timeout).
module svpwm_decoder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         da_on,
  input  logic         db_on,
  input  logic         dc_on,
  input  logic         pwm_sync,
  output logic signed [N:0] v_alpha,
  output logic signed [N:0] v_beta,
  output logic         out_valid,
  output logic         period_err,
  output logic         timeout
);
  import svpwm_pkg::*;

  localparam int PERIOD      = 2**N;
  localparam int TIMEOUT_LEN = 2 * PERIOD;

  logic [N+1:0]        win_cnt;
  logic                primed;
  logic [N-1:0]        da, db, dc;
  logic                s0_valid, s0_err;
  logic                s1_valid, s1_err;
  logic signed [N+2:0] s1_sa, sa_c;
  logic signed [N+1:0] s1_sb, sb_c;

  phase_duty_counter #(.N(N)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .phase_on(da_on), .sync(pwm_sync), .duty(da)
  );
  phase_duty_counter #(.N(N)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .phase_on(db_on), .sync(pwm_sync), .duty(db)
  );
  phase_duty_counter #(.N(N)) u_cnt_c (
    .clk(clk), .rst_n(rst_n), .phase_on(dc_on), .sync(pwm_sync), .duty(dc)
  );

  // Window length counter: reload 1 on sync (sync cycle is inclusive), saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (pwm_sync) begin
      win_cnt <= (N+2)'(1);
    end else if (win_cnt != '1) begin
      win_cnt <= win_cnt + (N+2)'(1);
    end
  end

`ifdef SVPWM_DEC_TIMEOUT_EN
  logic timeout_q;

  // Priming and missing-sync timeout: a stalled carrier drops priming so the
  // next sync only re-arms; sync always takes precedence over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (pwm_sync) begin
      primed    <= 1'b1;
      timeout_q <= 1'b0;
    end else if (win_cnt >= (N+2)'(TIMEOUT_LEN)) begin
      primed    <= 1'b0;
      timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  // Priming: the first sync after reset only arms the decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed <= 1'b0;
    end else if (pwm_sync) begin
      primed <= 1'b1;
    end
  end

  assign timeout = 1'b0;
`endif

  // Stage 0 qualifiers; duties themselves are latched inside the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_err   <= 1'b0;
    end else begin
      s0_valid <= pwm_sync && primed;
      if (pwm_sync) begin
        s0_err <= (win_cnt != (N+2)'(PERIOD));
      end
    end
  end

  // Clarke sums from the unsigned duties, zero-extended before subtracting.
  always_comb begin
    sa_c = '0;
    sb_c = '0;
    sa_c = $signed({2'b00, da, 1'b0}) - $signed({3'b000, db}) - $signed({3'b000, dc});
    sb_c = $signed({2'b00, db}) - $signed({2'b00, dc});
  end

  // Stage 1: register the Clarke sums with their sample qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_sa    <= '0;
      s1_sb    <= '0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_err <= s0_err;
        s1_sa  <= sa_c;
        s1_sb  <= sb_c;
      end
    end
  end

  // Stage 2: Q16 gain with rounding; outputs hold between valid strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      period_err <= 1'b0;
      v_alpha    <= '0;
      v_beta     <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        period_err <= s1_err;
        v_alpha    <= (N+1)'(q16_round(int'(s1_sa) * K_INV3));
        v_beta     <= (N+1)'(q16_round(int'(s1_sb) * K_INV_SQRT3));
      end
    end
  end

endmodule

// File: doc/svpwm_decoder.md
# svpwm_decoder

Receive-side counterpart of the SVPWM modulator. It samples the three phase gate signals over each carrier period and counts the on-time of each phase. It then applies an inverse Clarke transform to recover the alpha/beta voltage command that produced them. It sits in the loopback/monitor path for closed-loop self-check and gate-path fault detection.

## Interface
- `N`, 8: duty/voltage resolution in bits; nominal carrier period is 2**N clk cycles.
- `clk`  in  1  system clock; all inputs are synchronous to it.
- `rst_n`  in  1  asynchronous active-low reset.
- `da_on`, `db_on`, `dc_on`  in  1 each  phase gate signals (1 = high side on).
- `pwm_sync`  in  1  one-cycle carrier-start strobe.
- `v_alpha`  out  N+1  signed reconstructed alpha voltage.
- `v_beta`  out  N+1  signed reconstructed beta voltage.
- `out_valid`  out  1  one-cycle strobe; outputs updated.
- `period_err`  out  1  qualifies `out_valid`; measured window length ≠ 2**N.
- `timeout`  out  1  sticky no-sync flag (see Configuration).

## Operation
- **Window:** runs from a `pwm_sync` cycle (inclusive) to the next `pwm_sync` cycle (exclusive).
- **Per-phase counters:** each is N+1 bits and counts cycles with the phase input high.
- **Window counter:** N+2 bits, counts the window length; saturates at all-ones.
- **On `pwm_sync`:**
  - Counts are latched into stage 0.
  - Counters reload with the current-cycle sample: 1 if the input is high, else 0. The window counter reloads with 1.
- **`primed` flag:** cleared by reset. The first `pwm_sync` after reset only sets `primed`; no output is produced for the partial window.
- **Duty:** each latched count is saturated to N bits (2**N becomes 2**N−1), giving unsigned `da`, `db`, `dc`.
- **Stage 1:**
  - `sa = 2·da − db − dc`, signed N+3.
  - `sb = db − dc`, signed N+2.
- **Stage 2:**
  - `v_alpha = (sa·K_INV3 + 2**15) >>> 16`.
  - `v_beta = (sb·K_INV_SQRT3 + 2**15) >>> 16`.
  - Both results are truncated to N+1 bits. The range cannot overflow.
- **`period_err`:** set when the latched window length ≠ 2**N, including back-to-back syncs (length 1). It travels with its sample. Output is still produced.
- **Pipeline:** fully pipelined; accepts a `pwm_sync` every cycle.
- **Mid-operation reset:** `rst_n` low clears all counters, pipeline valids and `primed` immediately.

## Timing
- **Reset values:** `v_alpha` = 0, `v_beta` = 0, `out_valid` = 0, `period_err` = 0, `timeout` = 0.
- **Latency:** `pwm_sync` at cycle S gives stage 0 at S+1, stage 1 at S+2, and outputs with `out_valid` at S+3.
- **Output hold:** `v_alpha`, `v_beta` and `period_err` hold until the next `out_valid`. `out_valid` is high for exactly one cycle per accepted sync.
- **Sync on the reset-release cycle:** counts as the first (priming) sync.

## Configuration
- **`SVPWM_DEC_TIMEOUT_EN` defined:**
  - When the window counter reaches 2·2**N without a `pwm_sync`, `timeout` goes high and `primed` clears.
  - `timeout` stays high until the next `pwm_sync`. That sync re-primes and produces no output; `timeout` deasserts the cycle after it.
- **Not defined:** `timeout` is tied 0 and `primed` never clears except on reset.

## Structure
- **Package `svpwm_pkg`:**
  - `K_INV3 = 21845` (1/3, Q16).
  - `K_INV_SQRT3 = 37837` (1/√3, Q16).
  - `FRAC_BITS = 16`.
  - Shared with the modulator.
- **Sub-module `phase_duty_counter`:** instantiated three times. It holds the N+1-bit counter with sync reload and the latch/saturate logic.
- **Top level:** window counter, `primed`/timeout logic, Clarke pipeline.

## Test plan
- Syncs every 256 cycles (N=8); `da_on` always high, `db_on`/`dc_on` low → `v_alpha` = 170, `v_beta` = 0, `period_err` = 0 at S+3.
- `db_on` always high, others low → `v_alpha` = −85, `v_beta` = 147.
- Equal 128-cycle on-times on all phases → `v_alpha` = 0, `v_beta` = 0; first sync after reset gives no `out_valid`.
- Syncs on two consecutive cycles → `out_valid` on two consecutive cycles; the second has `period_err` = 1.
- With `SVPWM_DEC_TIMEOUT_EN`: no sync for 512 cycles → `timeout` = 1. The next sync gives no output and clears `timeout`; the following sync outputs normally.
- `rst_n` pulsed low mid-window → all outputs 0 immediately; the in-flight sample is never emitted.
